// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer.
//   seq_state_e  : 3-bit sequencer state encoding
//   fault_code_e : fault reason reported on fault_code_o
//   PC_*_SEL_RST : PC-select values driven out of reset
//   is_aligned() : word-alignment test for fetch addresses
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_EXEC     = 3'd4,
    ST_UPDATE   = 3'd5,
    ST_HALTED   = 3'd6,
    ST_FAULT    = 3'd7
  } seq_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE         = 2'd0,
    FAULT_IMEM_TIMEOUT = 2'd1,
    FAULT_MISALIGNED   = 2'd2
  } fault_code_e;

  localparam logic PC_ALU_SEL_RST  = 1'b1;  // +4 path
  localparam logic PC_NEXT_SEL_RST = 1'b0;  // pc_alu path

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the sequencer and instruction memory / decode / execute.
//   imem_req_valid/ready, imem_addr     : fetch request channel
//   imem_rsp_valid, imem_rsp_data       : fetch response (1-cycle pulse)
//   instr_valid/ready, instr            : instruction offered to decode
//   exec_done, exec_br_taken, exec_jalr : execute completion and PC-path info
// modport master : sequencer side; modport slave : memory/decode/execute side.
interface fetch_sequencer_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        exec_done;
  logic        exec_br_taken;
  logic        exec_jalr;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           exec_done, exec_br_taken, exec_jalr
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           exec_done, exec_br_taken, exec_jalr
  );
endinterface

// File: rtl/fetch_sequencer_watchdog_counter.sv
// Response watchdog for the fetch sequencer.
//   clk, rst   : clock, asynchronous active-high reset
//   clear_i    : force count to 0 (held while not waiting on imem)
//   enable_i   : count one cycle of waiting
//   expired_o  : high during the TIMEOUT_CYCLES-th enabled cycle after a clear
module watchdog_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // The count equals the number of enabled cycles already spent, so the
  // TIMEOUT_CYCLES-th waiting cycle sees TIMEOUT_CYCLES-1.
  assign expired_o = enable_i && (count_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle fetch/execute sequencer: drives PC select/load, runs the imem
// request/response handshake, offers each fetched word to decode and waits for
// execute completion before loading the next PC.
//   clk, rst        : clock, asynchronous active-high reset
//   run_i, halt_i   : start from IDLE / stop after the current instruction retires
//   pc_i            : current PC from the PC block
//   bus             : imem / decode / execute handshakes (master side)
//   pc_alu_sel_o    : 1 = +4, 0 = immediate increment
//   pc_next_sel_o   : 1 = writeback path (JALR), 0 = pc_alu path
//   pc_en_o         : one-cycle PC load enable, once per retired instruction
//   retired_o       : instructions retired since reset (wraps)
//   halted_o        : in HALTED
//   fault_o         : in FAULT (absorbing until reset)
//   fault_code_o    : 0 none, 1 imem timeout, 2 misaligned fetch
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_i,
  input  logic               halt_i,
  input  logic [31:0]        pc_i,
  fetch_sequencer_if.master  bus,
  output logic               pc_alu_sel_o,
  output logic               pc_next_sel_o,
  output logic               pc_en_o,
  output logic [CNT_W-1:0]   retired_o,
  output logic               halted_o,
  output logic               fault_o,
  output logic [1:0]         fault_code_o
);

  seq_state_e       state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic             alu_sel_q, alu_sel_d;
  logic             next_sel_q, next_sel_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [1:0]       fault_code_q, fault_code_d;

  logic req_valid;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  watchdog_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    alu_sel_d    = alu_sel_q;
    next_sel_d   = next_sel_q;
    retired_d    = retired_q;
    fault_code_d = fault_code_q;
    req_valid    = 1'b0;
    bus.instr_valid = 1'b0;
    pc_en_o      = 1'b0;
    wd_clear     = 1'b1;
    wd_enable    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // A misaligned PC never reaches the memory: no request is raised.
        if (!is_aligned(pc_i)) begin
          state_d      = ST_FAULT;
          fault_code_d = FAULT_MISALIGNED;
        end else begin
          req_valid = 1'b1;
          if (bus.imem_req_ready) state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        wd_clear  = 1'b0;
        wd_enable = 1'b1;
        // A response arriving on the timeout cycle still wins.
        if (bus.imem_rsp_valid) begin
          instr_d = bus.imem_rsp_data;
          state_d = ST_ISSUE;
        end else if (wd_expired) begin
          state_d      = ST_FAULT;
          fault_code_d = FAULT_IMEM_TIMEOUT;
        end
      end
      ST_ISSUE: begin
        bus.instr_valid = 1'b1;
        if (bus.instr_ready) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // PC selects are captured here so they are already stable in UPDATE.
        // JALR dominates: the branch request is dropped and +4 is selected.
        if (bus.exec_done) begin
          next_sel_d = bus.exec_jalr;
          alu_sel_d  = bus.exec_jalr ? 1'b1 : ~bus.exec_br_taken;
          state_d    = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        pc_en_o   = 1'b1;
        retired_d = retired_q + CNT_W'(1);
        state_d   = halt_i ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: begin
        if (!halt_i) state_d = ST_FETCH;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      alu_sel_q    <= PC_ALU_SEL_RST;
      next_sel_q   <= PC_NEXT_SEL_RST;
      retired_q    <= '0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      alu_sel_q    <= alu_sel_d;
      next_sel_q   <= next_sel_d;
      retired_q    <= retired_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = req_valid ? pc_i : 32'd0;
  assign bus.instr          = instr_q;
  assign pc_alu_sel_o       = alu_sel_q;
  assign pc_next_sel_o      = next_sel_q;
  assign retired_o          = retired_q;
  assign halted_o           = (state_q == ST_HALTED);
  assign fault_o            = (state_q == ST_FAULT);
  assign fault_code_o       = fault_code_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with TIMEOUT_CYCLES=8.
module tb_fetch_sequencer;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             halt;
  logic [31:0]      pc;
  logic             pc_alu_sel;
  logic             pc_next_sel;
  logic             pc_en;
  logic [CNT_W-1:0] retired;
  logic             halted;
  logic             fault;
  logic [1:0]       fault_code;

  int errors = 0;
  int checks = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .TIMEOUT_CYCLES(8),
    .CNT_W         (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run_i         (run),
    .halt_i        (halt),
    .pc_i          (pc),
    .bus           (bus),
    .pc_alu_sel_o  (pc_alu_sel),
    .pc_next_sel_o (pc_next_sel),
    .pc_en_o       (pc_en),
    .retired_o     (retired),
    .halted_o      (halted),
    .fault_o       (fault),
    .fault_code_o  (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    run                = 1'b0;
    halt               = 1'b0;
    pc                 = 32'd0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    bus.instr_ready    = 1'b1;
    bus.exec_done      = 1'b0;
    bus.exec_br_taken  = 1'b0;
    bus.exec_jalr      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Entered while the DUT is in FETCH; leaves it one cycle after UPDATE.
  task automatic run_instr(input logic [31:0] addr, input logic [31:0] data,
                           input logic br, input logic jalr, input logic hlt,
                           input int req_wait, input int dec_wait,
                           input logic [31:0] exp_ret,
                           input logic exp_alu, input logic exp_next, input logic chk_alu);
    pc = addr;
    for (int i = 0; i <= req_wait; i++) begin
      bus.imem_req_ready = (i == req_wait);
      // Stray responses while still requesting must be ignored.
      bus.imem_rsp_valid = (i != req_wait);
      bus.imem_rsp_data  = ~data;
      #1;
      check_eq("fetch_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check_eq("fetch_addr", bus.imem_addr, addr);
      check_eq("fetch_pc_en", 32'(pc_en), 32'd0);
      step();
    end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    #1;
    check_eq("wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
    step();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    for (int i = 0; i <= dec_wait; i++) begin
      bus.instr_ready = (i == dec_wait);
      #1;
      check_eq("issue_valid", 32'(bus.instr_valid), 32'd1);
      check_eq("issue_instr", bus.instr, data);
      step();
    end
    bus.exec_done     = 1'b1;
    bus.exec_br_taken = br;
    bus.exec_jalr     = jalr;
    halt              = hlt;
    #1;
    check_eq("exec_instr_valid", 32'(bus.instr_valid), 32'd0);
    step();
    bus.exec_done     = 1'b0;
    bus.exec_br_taken = 1'b0;
    bus.exec_jalr     = 1'b0;
    #1;
    check_eq("update_pc_en", 32'(pc_en), 32'd1);
    if (chk_alu) check_eq("update_alu_sel", 32'(pc_alu_sel), 32'(exp_alu));
    check_eq("update_next_sel", 32'(pc_next_sel), 32'(exp_next));
    check_eq("update_retired_before", retired, exp_ret - 32'd1);
    step();
    check_eq("post_pc_en", 32'(pc_en), 32'd0);
    check_eq("post_retired", retired, exp_ret);
    check_eq("post_next_sel_held", 32'(pc_next_sel), 32'(exp_next));
    if (chk_alu) check_eq("post_alu_sel_held", 32'(pc_alu_sel), 32'(exp_alu));
    $display("txn addr=0x%08h instr=0x%08h br=%0b jalr=%0b alu_sel=%0b next_sel=%0b retired=%0d",
             addr, bus.instr, br, jalr, pc_alu_sel, pc_next_sel, retired);
  endtask

  initial begin
    do_reset();

    // Reset state
    check_eq("rst_alu_sel", 32'(pc_alu_sel), 32'd1);
    check_eq("rst_next_sel", 32'(pc_next_sel), 32'd0);
    check_eq("rst_pc_en", 32'(pc_en), 32'd0);
    check_eq("rst_retired", retired, 32'd0);
    check_eq("rst_instr", bus.instr, 32'd0);
    check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("rst_addr", bus.imem_addr, 32'd0);
    check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_fault_code", 32'(fault_code), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);

    // 1: zero-wait straight-line instructions
    pc  = 32'h0000_0100;
    run = 1'b1;
    step();
    run = 1'b0;
    run_instr(32'h0000_0100, 32'h0010_0093, 1'b0, 1'b0, 1'b0, 0, 0, 32'd1, 1'b1, 1'b0, 1'b1);
    run_instr(32'h0000_0104, 32'h0020_0113, 1'b0, 1'b0, 1'b0, 0, 0, 32'd2, 1'b1, 1'b0, 1'b1);
    run_instr(32'h0000_0108, 32'h0030_0193, 1'b0, 1'b0, 1'b0, 0, 0, 32'd3, 1'b1, 1'b0, 1'b1);

    // 2: taken branch, then JALR together with branch
    run_instr(32'h0000_010C, 32'h0040_0063, 1'b1, 1'b0, 1'b0, 0, 0, 32'd4, 1'b0, 1'b0, 1'b1);
    run_instr(32'h0000_0110, 32'h0000_8067, 1'b1, 1'b1, 1'b0, 0, 0, 32'd5, 1'b1, 1'b1, 1'b0);

    // 3: imem backpressure 3 cycles, decode backpressure 2 cycles
    run_instr(32'h0000_0200, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 3, 2, 32'd6, 1'b1, 1'b0, 1'b1);

    // 6a: halt during EXEC -> retire then HALTED; release -> FETCH
    run_instr(32'h0000_0204, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 0, 0, 32'd7, 1'b1, 1'b0, 1'b1);
    check_eq("halted_set", 32'(halted), 32'd1);
    check_eq("halted_no_req", 32'(bus.imem_req_valid), 32'd0);
    step();
    check_eq("halted_hold", 32'(halted), 32'd1);
    halt = 1'b0;
    step();
    check_eq("unhalt_halted", 32'(halted), 32'd0);
    check_eq("unhalt_fetch", 32'(bus.imem_req_valid), 32'd1);
    $display("txn halt/resume retired=%0d", retired);

    // 6b: async reset while in ISSUE
    pc = 32'h0000_0208;
    step();                              // -> WAIT_RSP
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h1234_5678;
    step();                              // -> ISSUE
    bus.imem_rsp_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    check_eq("pre_rst_issue", 32'(bus.instr_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("arst_instr", bus.instr, 32'd0);
    check_eq("arst_retired", retired, 32'd0);
    check_eq("arst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("arst_alu_sel", 32'(pc_alu_sel), 32'd1);
    check_eq("arst_halted", 32'(halted), 32'd0);
    $display("txn async reset in ISSUE");

    // 4: no response -> timeout after 8 WAIT_RSP cycles
    do_reset();
    pc  = 32'h0000_0300;
    run = 1'b1;
    step();                              // -> FETCH
    run = 1'b0;
    step();                              // -> WAIT_RSP
    for (int i = 0; i < 8; i++) begin
      check_eq("wait_no_fault", 32'(fault), 32'd0);
      step();
    end
    check_eq("timeout_fault", 32'(fault), 32'd1);
    check_eq("timeout_code", 32'(fault_code), 32'd1);
    run                = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hCAFE_F00D;
    step();
    step();
    check_eq("fault_sticky", 32'(fault), 32'd1);
    check_eq("fault_code_sticky", 32'(fault_code), 32'd1);
    check_eq("fault_no_req", 32'(bus.imem_req_valid), 32'd0);
    check_eq("fault_no_issue", 32'(bus.instr_valid), 32'd0);
    check_eq("fault_instr_untouched", bus.instr, 32'd0);
    $display("txn imem timeout code=%0d", fault_code);

    // 4b: response on the timeout cycle wins
    do_reset();
    pc  = 32'h0000_0304;
    run = 1'b1;
    step();                              // -> FETCH
    run = 1'b0;
    step();                              // -> WAIT_RSP, cycle 0
    for (int i = 0; i < 7; i++) step();  // cycle 7
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hA5A5_0001;
    step();
    bus.imem_rsp_valid = 1'b0;
    check_eq("late_rsp_no_fault", 32'(fault), 32'd0);
    check_eq("late_rsp_issue", 32'(bus.instr_valid), 32'd1);
    check_eq("late_rsp_instr", bus.instr, 32'hA5A5_0001);
    $display("txn response on timeout cycle instr=0x%08h", bus.instr);

    // 5: misaligned fetch
    do_reset();
    pc  = 32'h0000_0006;
    run = 1'b1;
    step();                              // -> FETCH
    run = 1'b0;
    check_eq("misalign_no_req", 32'(bus.imem_req_valid), 32'd0);
    check_eq("misalign_addr", bus.imem_addr, 32'd0);
    step();
    check_eq("misalign_fault", 32'(fault), 32'd1);
    check_eq("misalign_code", 32'(fault_code), 32'd2);
    step();
    check_eq("misalign_still_no_req", 32'(bus.imem_req_valid), 32'd0);
    $display("txn misaligned fetch code=%0d", fault_code);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
